// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. a FIFO-buffered
// long-latency result source, with forced drain, pipeline stall and pending-rd mask.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_pipe_wen,
  input  logic [4:0]               i_pipe_rd_addr,
  input  logic [31:0]              i_pipe_rd_wdata,
  output logic                     o_pipe_stall,
  input  logic                     i_lu_valid,
  output logic                     o_lu_ready,
  input  logic [4:0]               i_lu_rd_addr,
  input  logic [31:0]              i_lu_wdata,
  output logic                     o_rd_wen,
  output logic [4:0]               o_rd_addr,
  output logic [31:0]              o_rd_wdata,
  output logic [31:0]              o_lu_pending,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          rd_wen_q;
  logic [4:0]    rd_addr_q;
  logic [31:0]   rd_wdata_q;
  logic [31:0]   pending_q, pending_d;

  logic lu_ready;
  logic push;
  logic pop;
  logic pipe_req;
  logic fifo_req;
  logic force_drain;
  logic grant_pipe;
  logic grant_fifo;

  // Ready depends only on the current occupancy; a same-cycle pop never raises it.
  assign lu_ready    = (count_q < DEPTH_C);
  assign push        = i_lu_valid && lu_ready && (i_lu_rd_addr != 5'd0);
  assign pipe_req    = i_pipe_wen && (i_pipe_rd_addr != 5'd0);
  assign fifo_req    = (count_q != '0);
  assign force_drain = fifo_req && ((wait_q >= MAX_WAIT_C) || (count_q == DEPTH_C));
  assign grant_fifo  = fifo_req && (force_drain || !pipe_req);
  assign grant_pipe  = pipe_req && !force_drain;
  assign pop         = grant_fifo;

  assign o_pipe_stall = pipe_req && force_drain;
  assign o_lu_ready   = lu_ready;
  assign o_rd_wen     = rd_wen_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_rd_wdata   = rd_wdata_q;
  assign o_lu_pending = pending_q;
  assign o_fifo_count = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // The head's age only accumulates while it is queued and losing to the pipe.
  always_comb begin
    wait_d = wait_q;
    if (!fifo_req || grant_fifo) begin
      wait_d = '0;
    end else if (wait_q < MAX_WAIT_C) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // Next-state view of every slot, so the pending mask lines up with the updated FIFO.
  logic [31:0] entry_onehot [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [AW-1:0] offset;
    logic [4:0]    addr_nx;
    logic          valid_nx;

    assign offset   = AW'(gi) - rd_ptr_d;
    assign valid_nx = ({1'b0, offset} < count_d);
    assign addr_nx  = (push && (wr_ptr_q == AW'(gi))) ? i_lu_rd_addr : addr_mem[gi];
    assign entry_onehot[gi] = valid_nx ? (32'd1 << addr_nx) : 32'd0;
  end

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_d = pending_d | entry_onehot[i];
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= i_lu_rd_addr;
      data_mem[wr_ptr_q] <= i_lu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      rd_wen_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      rd_wen_q  <= grant_pipe || grant_fifo;
      // Address/data hold their last committed value when no write is granted.
      if (grant_pipe) begin
        rd_addr_q  <= i_pipe_rd_addr;
        rd_wdata_q <= i_pipe_rd_wdata;
      end else if (grant_fifo) begin
        rd_addr_q  <= addr_mem[rd_ptr_q];
        rd_wdata_q <= data_mem[rd_ptr_q];
      end
    end
  end

endmodule
